// File: rtl/rv32i_types.sv
// Shared types and constants for the L2 eviction-write-buffer drain path.
// Holds the drain FSM state encoding and the default line/beat geometry.
package rv32i_types;

  localparam int EWB_LINE_WIDTH = 256;
  localparam int EWB_BEAT_WIDTH = 64;
  localparam int EWB_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_BURST,
    ST_POP
  } ewb_drain_state_t;

  // Clears the byte-offset bits so memory always sees the start of the line.
  function automatic logic [EWB_ADDR_WIDTH-1:0] line_align(
    input logic [EWB_ADDR_WIDTH-1:0] addr,
    input int unsigned               line_bytes
  );
    return addr & ~(EWB_ADDR_WIDTH'(line_bytes) - EWB_ADDR_WIDTH'(1));
  endfunction

endpackage

// File: rtl/ewb_burst_serializer.sv
// Holds one evicted line and presents it one beat at a time, lowest beat first.
// The beat index advances once per accepted beat and restarts on every load.
module ewb_burst_serializer
  import rv32i_types::*;
#(
  parameter int WIDTH = EWB_LINE_WIDTH,
  parameter int BEAT  = EWB_BEAT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             adv_i,
  output logic [BEAT-1:0]  beat_o,
  output logic             last_o
);

  localparam int BEATS = WIDTH / BEAT;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [BEATS-1:0][BEAT-1:0] line_q;
  logic [IDX_W-1:0]           idx_q;

  // NOTE: the line register is reset like every other flop so the burst bus is
  // never X after reset; a true RAM array would not get a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
      idx_q  <= '0;
    end else if (load_i) begin
      line_q <= data_i;
      idx_q  <= '0;
    end else if (adv_i) begin
      idx_q  <= idx_q + 1'b1;
    end
  end

  assign beat_o = line_q[idx_q];
  assign last_o = (idx_q == IDX_W'(BEATS - 1));

endmodule

// File: rtl/ewb_drain.sv
// Drains the oldest dirty line of the L2 eviction write buffer to memory as a beat burst,
// popping it only after the last beat is accepted. Define EWB_DRAIN_PERF_EN for perf counters.
module ewb_drain
  import rv32i_types::*;
#(
  parameter int WIDTH = EWB_LINE_WIDTH,
  parameter int BEAT  = EWB_BEAT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ewb_empty_i,
  input  logic [WIDTH-1:0] ewb_data_i,
  input  logic [31:0]      ewb_addr_i,
  output logic             ewb_yumi_o,
  output logic             drain_req_o,
  input  logic             drain_grant_i,
  output logic [31:0]      mem_address_o,
  output logic [BEAT-1:0]  mem_burst_o,
  output logic             mem_write_o,
  input  logic             mem_resp_i
`ifdef EWB_DRAIN_PERF_EN
  ,
  output logic [31:0]      lines_drained_o,
  output logic [31:0]      grant_wait_o
`endif
);

  ewb_drain_state_t state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic             load;
  logic             adv;
  logic [BEAT-1:0]  beat;
  logic             last_beat;

  ewb_burst_serializer #(
    .WIDTH (WIDTH),
    .BEAT  (BEAT)
  ) u_serializer (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .data_i (ewb_data_i),
    .adv_i  (adv),
    .beat_o (beat),
    .last_o (last_beat)
  );

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // NOTE: every signal driven here gets a default first; a path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    load          = 1'b0;
    adv           = 1'b0;
    ewb_yumi_o    = 1'b0;
    drain_req_o   = 1'b0;
    mem_write_o   = 1'b0;
    mem_address_o = '0;
    mem_burst_o   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (!ewb_empty_i) state_d = ST_REQ;
      end
      ST_REQ: begin
        drain_req_o = 1'b1;
        // The head is snapshotted at grant; later head changes cannot tear the burst.
        if (drain_grant_i) begin
          load    = 1'b1;
          addr_d  = line_align(ewb_addr_i, WIDTH / 8);
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        drain_req_o   = 1'b1;
        mem_write_o   = 1'b1;
        mem_address_o = addr_q;
        mem_burst_o   = beat;
        if (mem_resp_i) begin
          adv = 1'b1;
          if (last_beat) state_d = ST_POP;
        end
      end
      ST_POP: begin
        // Pop only now, so the line stayed hittable in the buffer for the whole write.
        ewb_yumi_o = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef EWB_DRAIN_PERF_EN
  logic [31:0] lines_drained_q;
  logic [31:0] grant_wait_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lines_drained_q <= '0;
      grant_wait_q    <= '0;
    end else begin
      if (state_q == ST_POP && lines_drained_q != '1)
        lines_drained_q <= lines_drained_q + 32'd1;
      if (state_q == ST_REQ && !drain_grant_i && grant_wait_q != '1)
        grant_wait_q <= grant_wait_q + 32'd1;
    end
  end

  assign lines_drained_o = lines_drained_q;
  assign grant_wait_o    = grant_wait_q;
`endif

`ifndef SYNTHESIS
  // The arbiter must keep the grant for the whole burst; the FSM carries on regardless.
  grant_held_in_burst : assert property (
    @(posedge clk) disable iff (rst) (state_q == ST_BURST) |-> drain_grant_i
  );
`endif

endmodule
